// File: rtl/test_env_controller.sv
// test_env_controller: assembles UART command frames into environment bus
// cycles and streams a status-prefixed response back to the UART TX.
// Ports:
//   CLK_SYS, RST        clock, async active-high reset
//   RX_DATA/RX_VALID    received frame bytes (no backpressure)
//   TX_DATA/TX_VALID/   response byte stream, advanced on
//   TX_READY            TX_VALID && TX_READY
//   SEL, ADR, RnW,      environment bus toward the DUT mux
//   DATA_OUT, START_FLAG
//   DATA_IN, HEAD_INFO, environment read data, header word, ready
//   RDY_FLAG
//   BUSY, ERR           not idle; one-cycle error pulse
// Option: TEST_ENV_CTRL_CHECKSUM_EN adds an XOR check byte to the
// frame (state RX4) and a trailing XOR byte to every response.
module test_env_controller #(
  parameter int BITWIDTH_DATA   = 16,
  parameter int BITWIDTH_ADR    = 6,
  parameter int NUM_DUT         = 4,
  parameter int NUM_BITS_HEADER = 32,
  parameter int READ_LATENCY    = 2,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic                       CLK_SYS,
  input  logic                       RST,
  input  logic [7:0]                 RX_DATA,
  input  logic                       RX_VALID,
  output logic [7:0]                 TX_DATA,
  output logic                       TX_VALID,
  input  logic                       TX_READY,
  output logic [$clog2(NUM_DUT):0]   SEL,
  output logic [BITWIDTH_ADR-1:0]    ADR,
  output logic                       RnW,
  output logic [BITWIDTH_DATA-1:0]   DATA_OUT,
  output logic                       START_FLAG,
  input  logic [BITWIDTH_DATA-1:0]   DATA_IN,
  input  logic [NUM_BITS_HEADER-1:0] HEAD_INFO,
  input  logic                       RDY_FLAG,
  output logic                       BUSY,
  output logic                       ERR
);

  localparam int SW = $clog2(NUM_DUT) + 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + READ_LATENCY + 2);
  localparam logic [SW-1:0] SEL_MAX = SW'(NUM_DUT);
  localparam logic [CW-1:0] TMO  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO1 = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] RLAT = CW'(READ_LATENCY);

  localparam logic [1:0] C_WR = 2'd0;
  localparam logic [1:0] C_RD = 2'd1;
  localparam logic [1:0] C_ST = 2'd2;
  localparam logic [1:0] C_HD = 2'd3;

  typedef enum logic [2:0] {
    S_RX0,
    S_RX1,
    S_RX2,
    S_RX3,
`ifdef TEST_ENV_CTRL_CHECKSUM_EN
    S_RX4,
`endif
    S_EXEC,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [7:0]               b0_q;
  logic [SW-1:0]            b1_q;
  logic [7:0]               b2_q;
  logic [1:0]               cmd_q;
  logic                     ok_q;
  logic [BITWIDTH_ADR-1:0]  adr_q;
  logic [SW-1:0]            sel_q;
  logic [BITWIDTH_DATA-1:0] dout_q;
  logic [CW-1:0]            cnt_q;
  logic [47:0]              resp_q, resp_d;
  logic [2:0]               rem_q, len_d;
  logic                     err_q, err_d;
`ifdef TEST_ENV_CTRL_CHECKSUM_EN
  logic [7:0]               chk_q;
`endif

  logic        cap, cap_ok;
  logic [31:0] pl;
  logic [15:0] din16;
  logic [15:0] dout16;
  logic [7:0]  st, ck;
  logic        sel_ok, in_frame, in_exec;

  assign sel_ok   = (b1_q <= SEL_MAX);
  assign dout16   = {b2_q, RX_DATA};
  assign in_exec  = state_q inside {S_EXEC, S_WAIT, S_RESP};
  assign in_frame = !(state_q inside {S_RX0, S_EXEC, S_WAIT, S_RESP});

  always_comb begin
    din16 = '0;
    din16[BITWIDTH_DATA-1:0] = DATA_IN;
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    cap     = 1'b0;
    cap_ok  = 1'b0;
    pl      = '0;
    unique case (state_q)
      S_RX0: if (RX_VALID) state_d = S_RX1;
      S_RX1: if (RX_VALID) state_d = S_RX2;
      S_RX2: if (RX_VALID) state_d = S_RX3;
`ifdef TEST_ENV_CTRL_CHECKSUM_EN
      S_RX3: if (RX_VALID) state_d = S_RX4;
      S_RX4: if (RX_VALID) state_d = S_EXEC;
`else
      S_RX3: if (RX_VALID) state_d = S_EXEC;
`endif
      S_EXEC: begin
        if (!ok_q) begin
          cap   = 1'b1;
          err_d = 1'b1;
        end else begin
          unique case (cmd_q)
            C_WR: begin
              cap    = 1'b1;
              cap_ok = 1'b1;
            end
            C_RD: begin
              // cnt_q restarts at 0 on EXEC entry
              if (cnt_q == RLAT) begin
                cap    = 1'b1;
                cap_ok = 1'b1;
                pl     = {16'h0, din16};
              end
            end
            C_ST: state_d = S_WAIT;
            default: begin
              cap    = 1'b1;
              cap_ok = 1'b1;
              pl     = HEAD_INFO;
            end
          endcase
        end
      end
      S_WAIT: begin
        if (RDY_FLAG) begin
          cap    = 1'b1;
          cap_ok = 1'b1;
          pl     = {16'h0, din16};
        end else if (cnt_q >= TMO1) begin
          cap   = 1'b1;
          err_d = 1'b1;
        end
      end
      S_RESP: begin
        if (TX_READY && rem_q == 3'd1) state_d = S_RX0;
      end
      default: state_d = S_RX0;
    endcase
    if (cap) state_d = S_RESP;
    // partial frame abandoned after an over-long gap
    if (in_frame && !RX_VALID && cnt_q >= TMO) begin
      state_d = S_RX0;
      err_d   = 1'b1;
    end
    // bytes arriving while a command is in flight are lost
    if (in_exec && RX_VALID) err_d = 1'b1;
  end

  always_comb begin
    st = {cap_ok ? 4'hA : 4'hE, 2'b00, cmd_q};
    ck = 8'h00;
`ifdef TEST_ENV_CTRL_CHECKSUM_EN
    ck = st ^ pl[31:24] ^ pl[23:16] ^ pl[15:8] ^ pl[7:0];
`endif
    unique case (cmd_q)
      C_WR: begin
        resp_d = {st, ck, 32'h0};
        len_d  = 3'd1;
      end
      C_HD: begin
        resp_d = {st, pl, ck};
        len_d  = 3'd5;
      end
      default: begin
        resp_d = {st, pl[15:0], ck, 16'h0};
        len_d  = 3'd3;
      end
    endcase
`ifdef TEST_ENV_CTRL_CHECKSUM_EN
    len_d = len_d + 3'd1;
`endif
  end

  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      state_q <= S_RX0;
      b0_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      cmd_q   <= C_WR;
      ok_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
`ifdef TEST_ENV_CTRL_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_d != state_q) cnt_q <= '0;
      else if (cnt_q != '1) cnt_q <= cnt_q + CW'(1);
      if (RX_VALID && state_q == S_RX0) b0_q <= RX_DATA;
      if (RX_VALID && state_q == S_RX1) b1_q <= RX_DATA[SW-1:0];
      if (RX_VALID && state_q == S_RX2) b2_q <= RX_DATA;
      if (RX_VALID && state_q == S_RX3) begin
        cmd_q  <= b0_q[7:6];
        adr_q  <= b0_q[BITWIDTH_ADR-1:0];
        dout_q <= dout16[BITWIDTH_DATA-1:0];
        ok_q   <= sel_ok;
        if (sel_ok) sel_q <= b1_q;
      end
`ifdef TEST_ENV_CTRL_CHECKSUM_EN
      if (RX_VALID && state_q == S_RX0) chk_q <= RX_DATA;
      else if (RX_VALID && in_frame) chk_q <= chk_q ^ RX_DATA;
      if (RX_VALID && state_q == S_RX4 && RX_DATA != chk_q)
        ok_q <= 1'b0;
`endif
      if (cap) begin
        resp_q <= resp_d;
        rem_q  <= len_d;
      end else if (TX_VALID && TX_READY) begin
        resp_q <= {resp_q[39:0], 8'h00};
        rem_q  <= rem_q - 3'd1;
      end
    end
  end

  assign TX_DATA    = resp_q[47:40];
  assign TX_VALID   = (state_q == S_RESP);
  assign SEL        = sel_q;
  assign ADR        = adr_q;
  assign DATA_OUT   = dout_q;
  assign RnW        = !(state_q == S_EXEC && cmd_q == C_WR && ok_q);
  assign START_FLAG = (state_q == S_EXEC) && (cmd_q == C_ST) && ok_q;
  assign BUSY       = (state_q != S_RX0);
  assign ERR        = err_q;

endmodule

// File: tb/tb_test_env_controller.sv
// tb_test_env_controller: directed and random frames checked
// against a byte-level response model.
module tb_test_env_controller;

  localparam int RL      = 2;
  localparam int NDUT    = 4;
  localparam int TMO     = 1023;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b0;
  logic [2:0]  SEL;
  logic [5:0]  ADR;
  logic        RnW;
  logic [15:0] DATA_OUT;
  logic        START_FLAG;
  logic [15:0] DATA_IN = 16'h0;
  logic [31:0] HEAD_INFO = 32'h0;
  logic        RDY_FLAG = 1'b0;
  logic        BUSY;
  logic        ERR;

  test_env_controller #(
    .BITWIDTH_DATA(16), .BITWIDTH_ADR(6), .NUM_DUT(NDUT),
    .NUM_BITS_HEADER(32), .READ_LATENCY(RL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK_SYS(CLK), .RST(RST),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY),
    .SEL(SEL), .ADR(ADR), .RnW(RnW),
    .DATA_OUT(DATA_OUT), .START_FLAG(START_FLAG),
    .DATA_IN(DATA_IN), .HEAD_INFO(HEAD_INFO),
    .RDY_FLAG(RDY_FLAG), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int n_wr  = 0;
  int n_st  = 0;
  int n_err = 0;
  logic [2:0] cur_sel = 3'd0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always @(negedge CLK) begin
    if (!RnW) n_wr++;
    if (START_FLAG) n_st++;
    if (ERR) n_err++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
`ifdef TEST_ENV_CTRL_CHECKSUM_EN
    send_byte(b0 ^ b1 ^ b2 ^ b3);
`endif
  endtask

  // Expected response bytes from command, select validity and timeout.
  function automatic void model(input int cmd, input bit vld,
                                input bit to, input logic [15:0] d,
                                input logic [31:0] h);
    bit ok;
    logic [7:0] x;
    ok = vld && !to;
    exp_q.delete();
    exp_q.push_back((ok ? 8'hA0 : 8'hE0) | 8'(cmd));
    if (cmd == 1 || cmd == 2) begin
      exp_q.push_back(ok ? d[15:8] : 8'h00);
      exp_q.push_back(ok ? d[7:0] : 8'h00);
    end
    if (cmd == 3)
      for (int i = 3; i >= 0; i--)
        exp_q.push_back(ok ? h[8*i +: 8] : 8'h00);
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
`ifdef TEST_ENV_CTRL_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  task automatic collect(input int n, input int stall);
    logic [7:0] hold;
    int k;
    got_q.delete();
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (!TX_VALID && k < 3000) begin
        tick();
        k++;
      end
      if (!TX_VALID) begin
        chk("tx_wait", TX_VALID, 1'b1);
        return;
      end
      hold = TX_DATA;
      for (int s = 0; s < stall; s++) begin
        tick();
        chk("tx_hold", {TX_VALID, TX_DATA}, {1'b1, hold});
      end
      got_q.push_back(TX_DATA);
      TX_READY = 1'b1;
      tick();
      TX_READY = 1'b0;
    end
  endtask

  task automatic cmp_bytes(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, got_q[i], exp_q[i]);
  endtask

  task automatic run_cmd(input int cmd, input logic [5:0] adr,
                         input logic [2:0] sel, input logic [15:0] data,
                         input logic [15:0] din, input logic [31:0] head,
                         input int rdy_dly, input int stall);
    int w0, s0, e0, k;
    bit vld, to;
    vld = (int'(sel) <= NDUT);
    to  = (cmd == 2) && vld && (rdy_dly < 0);
    w0 = n_wr;
    s0 = n_st;
    e0 = n_err;
    HEAD_INFO = head;
    RDY_FLAG  = 1'b0;
    DATA_IN   = (cmd == 1) ? din : 16'($urandom);
    send_frame({2'(cmd), adr}, {5'b0, sel}, data[15:8], data[7:0]);
    chk("rnw_exec", RnW, !(cmd == 0 && vld));
    chk("start_exec", START_FLAG, (cmd == 2 && vld));
    chk("sel_exec", SEL, vld ? sel : cur_sel);
    if (cmd == 0 && vld) begin
      chk("adr", ADR, adr);
      chk("data_out", DATA_OUT, data);
    end
    if (cmd == 2 && vld && rdy_dly >= 0) begin
      repeat (rdy_dly) tick();
      DATA_IN  = din;
      RDY_FLAG = 1'b1;
    end
    k = 0;
    while (!TX_VALID && k < 3000) begin
      tick();
      k++;
    end
    RDY_FLAG = 1'b0;
    if (vld && cmd != 2) chk("latency", k, (cmd == 1) ? RL + 1 : 1);
    DATA_IN = ~din;
    model(cmd, vld, to, din, head);
    collect(exp_q.size(), stall);
    cmp_bytes("resp");
    chk("tx_done", TX_VALID, 1'b0);
    chk("busy_done", BUSY, 1'b0);
    tick();
    chk("rnw_pulses", n_wr - w0, (cmd == 0 && vld) ? 1 : 0);
    chk("start_pulses", n_st - s0, (cmd == 2 && vld) ? 1 : 0);
    chk("err_pulses", n_err - e0, (!vld || to) ? 1 : 0);
    if (vld) cur_sel = sel;
    chk("sel_after", SEL, cur_sel);
  endtask

  initial begin
    int e0, k, c;
    bit seen;
    logic [2:0] s;
    repeat (3) tick();
    chk("rst_sel", SEL, 3'd0);
    chk("rst_adr", ADR, 6'd0);
    chk("rst_rnw", RnW, 1'b1);
    chk("rst_dout", DATA_OUT, 16'h0);
    chk("rst_start", START_FLAG, 1'b0);
    chk("rst_txv", TX_VALID, 1'b0);
    chk("rst_txd", TX_DATA, 8'h00);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_err", ERR, 1'b0);
    RST = 1'b0;
    tick();

    run_cmd(0, 6'd5, 3'd3, 16'h1234, 16'h0, 32'h0, 0, 0);
    run_cmd(1, 6'd5, 3'd3, 16'h0, 16'hBEEF, 32'h0, 0, 0);
    run_cmd(1, 6'd5, 3'd3, 16'h0, 16'hBEEF, 32'h0, 0, 5);
    run_cmd(2, 6'd0, 3'd1, 16'h0007, 16'h0007, 32'h0, 10, 0);
    run_cmd(2, 6'd0, 3'd1, 16'h0007, 16'h0007, 32'h0, -1, 0);
    run_cmd(3, 6'd0, 3'd2, 16'h0, 16'h0, 32'h10C1_0410, 0, 0);
    run_cmd(0, 6'd0, 3'd7, 16'h1234, 16'h0, 32'h0, 0, 0);
    run_cmd(0, 6'd9, 3'd4, 16'hA5A5, 16'h0, 32'h0, 0, 0);

    e0 = n_err;
    seen = 1'b0;
    send_byte(8'h05);
    send_byte(8'h03);
    repeat (1100) begin
      tick();
      seen = seen | TX_VALID;
    end
    chk("partial_no_tx", seen, 1'b0);
    chk("partial_idle", BUSY, 1'b0);
    chk("partial_err", n_err - e0, 1);
    run_cmd(0, 6'd1, 3'd2, 16'h0F0F, 16'h0, 32'h0, 0, 0);

    e0 = n_err;
    DATA_IN = 16'h1111;
    send_frame(8'h41, 8'h02, 8'h00, 8'h00);
    k = 0;
    while (!TX_VALID && k < 100) begin
      tick();
      k++;
    end
    chk("drop_resp", TX_VALID, 1'b1);
    send_byte(8'h55);
    model(1, 1'b1, 1'b0, 16'h1111, 32'h0);
    collect(exp_q.size(), 0);
    cmp_bytes("drop_bytes");
    tick();
    chk("drop_err", n_err - e0, 1);
    chk("drop_idle", BUSY, 1'b0);
    cur_sel = 3'd2;

    for (int i = 0; i < 40; i++) begin
      c = $urandom_range(0, 3);
      s = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4))
                                     : 3'($urandom_range(5, 7));
      run_cmd(c, 6'($urandom), s, 16'($urandom), 16'($urandom),
              $urandom, $urandom_range(0, 15), $urandom_range(0, 3));
    end

    HEAD_INFO = 32'hCAFE_F00D;
    send_frame(8'hC0, 8'h01, 8'h00, 8'h00);
    k = 0;
    while (!TX_VALID && k < 100) begin
      tick();
      k++;
    end
    chk("rst_mid_resp", TX_VALID, 1'b1);
    TX_READY = 1'b1;
    tick();
    TX_READY = 1'b0;
    RST = 1'b1;
    #1;
    chk("rst_mid_txv", TX_VALID, 1'b0);
    chk("rst_mid_busy", BUSY, 1'b0);
    chk("rst_mid_sel", SEL, 3'd0);
    repeat (2) tick();
    RST = 1'b0;
    cur_sel = 3'd0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen = seen | TX_VALID;
    end
    chk("rst_no_resume", seen, 1'b0);
    run_cmd(3, 6'd0, 3'd0, 16'h0, 16'h0, 32'h0102_0304, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
